// File: rtl/mux_nch_reg_if.sv
// Handshake bundle for mux_nch_reg: per-channel valid/ready inputs, control and
// the registered valid/ready output. The master side drives data and controls.
interface mux_nch_reg_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic          enb;
    logic          mode;
    logic [SW-1:0] s;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  o;
    logic [SW-1:0] o_ch;
    logic          o_valid;
    logic          o_ready;

    modport master (
        output enb, mode, s, in_data, in_valid, o_ready,
        input  in_ready, o, o_ch, o_valid
    );

    modport slave (
        input  enb, mode, s, in_data, in_valid, o_ready,
        output in_ready, o, o_ch, o_valid
    );
endinterface

// File: rtl/mux_nch_reg.sv
// N-channel registered multiplexer with valid/ready on every channel and the output.
// Channel choice is a fixed select or round-robin starting at the pointer.
module mux_nch_reg #(
    parameter int N = 4,
    parameter int W = 8
) (
    input logic           clk,
    input logic           rst,
    mux_nch_reg_if.slave  bus
);
    localparam int SW = $clog2(N);

    logic [W-1:0]  o_q;
    logic [SW-1:0] ch_q;
    logic          o_valid_q;
    logic [SW-1:0] ptr;

    logic          load;
    logic          grant_ok;
    logic [SW-1:0] grant_idx;
    logic          accept;
    logic [W-1:0]  sel_data;
    logic [N-1:0]  ready_c;
    logic [SW-1:0] ptr_next;

    // Gating with rst keeps in_ready low during reset regardless of the held beat.
    assign load   = ~rst & bus.enb & (~o_valid_q | bus.o_ready);
    assign accept = load & grant_ok;

    always_comb begin
        int c;
        grant_ok  = 1'b0;
        grant_idx = '0;
        c         = 0;
        if (!bus.mode) begin
            for (int i = 0; i < N; i++) begin
                if (bus.s == SW'(i) && bus.in_valid[i]) begin
                    grant_ok  = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                c = int'(ptr) + k;
                if (c >= N) c = c - N;
                if (!grant_ok && bus.in_valid[c]) begin
                    grant_ok  = 1'b1;
                    grant_idx = SW'(c);
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        ready_c  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) begin
                sel_data   = bus.in_data[i*W +: W];
                ready_c[i] = load & grant_ok;
            end
        end
    end

    assign ptr_next = (int'(grant_idx) == N - 1) ? '0 : grant_idx + SW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q       <= '0;
            ch_q      <= '0;
            o_valid_q <= 1'b0;
            ptr       <= '0;
        end else if (accept) begin
            o_q       <= sel_data;
            ch_q      <= grant_idx;
            o_valid_q <= 1'b1;
            if (bus.mode) ptr <= ptr_next;
        end else if (o_valid_q && bus.o_ready) begin
            o_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready = ready_c;
    assign bus.o        = o_q;
    assign bus.o_ch     = ch_q;
    assign bus.o_valid  = o_valid_q;
endmodule

// File: tb/tb_mux_nch_reg.sv
// Directed plus randomized bench for mux_nch_reg (N=4, W=8) against a
// cycle-level behavioural model of grant, output register and round-robin pointer.
module tb_mux_nch_reg;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_nch_reg_if #(.N(N), .W(W)) bus ();
    mux_nch_reg #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_o     = 8'h00;
    logic [1:0] m_ch    = 2'd0;
    bit         m_valid = 1'b0;
    int         m_ptr   = 0;
    bit         m_known = 1'b0;
    logic [3:0] m_ready;

    function automatic logic [3:0] model_ready();
        int g;
        int c;
        g = -1;
        if (rst || !bus.enb || (m_valid && !bus.o_ready)) return 4'b0000;
        if (!bus.mode) begin
            if (int'(bus.s) < N && bus.in_valid[bus.s]) g = int'(bus.s);
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && bus.in_valid[c]) g = c;
            end
        end
        return (g < 0) ? 4'b0000 : 4'(1 << g);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        int g;
        @(negedge clk);
        m_ready = model_ready();
        chk("in_ready", 32'(bus.in_ready), 32'(m_ready));
        if (m_known) begin
            chk("o", 32'(bus.o), 32'(m_o));
            chk("o_ch", 32'(bus.o_ch), 32'(m_ch));
            chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
        end
        @(posedge clk);
        g = -1;
        for (int i = 0; i < N; i++) if (m_ready[i]) g = i;
        if (rst) begin
            m_o = 8'h00; m_ch = 2'd0; m_valid = 1'b0; m_ptr = 0; m_known = 1'b1;
        end else if (g >= 0) begin
            m_o     = bus.in_data[g*W +: W];
            m_ch    = 2'(g);
            m_valid = 1'b1;
            if (bus.mode) m_ptr = (g + 1) % N;
        end else if (m_valid && bus.o_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.enb = 1'b1; bus.mode = 1'b0; bus.s = 2'd0;
        bus.in_valid = 4'b1111; bus.in_data = 32'h13121110; bus.o_ready = 1'b1;

        // Reset held two cycles with all channels valid
        cycle();
        cycle();
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_o", 32'(bus.o), 32'h0);
        chk("rst_o_ch", 32'(bus.o_ch), 32'h0);
        chk("rst_o_valid", 32'(bus.o_valid), 32'h0);

        // Round-robin, all valid: first grant after release is channel 0
        rst = 1'b0; bus.mode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_all_ch", 32'(bus.o_ch), 32'(k % 4));
            chk("rr_all_o", 32'(bus.o), 32'(8'h10 + k % 4));
            chk("rr_all_valid", 32'(bus.o_valid), 32'h1);
        end

        // Fixed select
        bus.mode = 1'b0; bus.s = 2'd2; bus.in_valid = 4'b0100; bus.in_data = 32'h13A51110;
        #1;
        chk("fix_in_ready", 32'(bus.in_ready), 32'h4);
        cycle();
        chk("fix_o", 32'(bus.o), 32'hA5);
        chk("fix_o_ch", 32'(bus.o_ch), 32'h2);
        chk("fix_o_valid", 32'(bus.o_valid), 32'h1);
        bus.in_valid = 4'b1011;
        #1;
        chk("fix_nogrant", 32'(bus.in_ready), 32'h0);
        cycle();
        chk("fix_drain", 32'(bus.o_valid), 32'h0);

        // Round-robin sparse from ptr=0
        rst = 1'b1;
        cycle();
        rst = 1'b0; bus.mode = 1'b1; bus.in_valid = 4'b1010; bus.in_data = 32'h13121110;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr_sparse_ch", 32'(bus.o_ch), (k % 2 == 0) ? 32'h1 : 32'h3);
        end

        // Backpressure: park 0x5C then stall
        bus.mode = 1'b0; bus.s = 2'd0; bus.in_valid = 4'b0001; bus.in_data = 32'h1312115C;
        cycle();
        chk("bp_load", 32'(bus.o), 32'h5C);
        bus.o_ready = 1'b0; bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.in_data = 32'h13121177;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
            cycle();
            chk("bp_o_hold", 32'(bus.o), 32'h5C);
            chk("bp_ch_hold", 32'(bus.o_ch), 32'h0);
        end
        bus.o_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'h1);
        cycle();
        chk("bp_new_o", 32'(bus.o), 32'h77);
        chk("bp_new_valid", 32'(bus.o_valid), 32'h1);

        // Enable low drains the held beat, no accepts
        bus.enb = 1'b0;
        #1;
        chk("enb_in_ready", 32'(bus.in_ready), 32'h0);
        cycle();
        chk("enb_drain", 32'(bus.o_valid), 32'h0);
        cycle();
        chk("enb_idle", 32'(bus.o_valid), 32'h0);

        // Reset while a beat is held under backpressure
        bus.enb = 1'b1;
        cycle();
        bus.o_ready = 1'b0;
        cycle();
        chk("hold_valid", 32'(bus.o_valid), 32'h1);
        rst = 1'b1;
        cycle();
        chk("midrst_valid", 32'(bus.o_valid), 32'h0);
        chk("midrst_o", 32'(bus.o), 32'h0);
        rst = 1'b0; bus.o_ready = 1'b1;

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            rst          = ($urandom_range(0, 49) == 0);
            bus.enb      = ($urandom_range(0, 9) != 0);
            bus.mode     = 1'($urandom);
            bus.s        = 2'($urandom);
            bus.in_valid = 4'($urandom);
            bus.in_data  = $urandom;
            bus.o_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
